// File: rtl/uart_frame_rx_if.sv
// Frame output channel of the UART frame receiver.
// Valid/ready handshake carrying one assembled image frame.
interface uart_frame_rx_if #(
   parameter int W = 392
) ();
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that packs NUM_WORDS bytes into one image frame.
// Handles glitch rejection, framing errors, idle timeout and overrun.
module uart_frame_rx #(
   parameter int R_I              = 7,
   parameter int C_I              = 7,
   parameter int W_I              = 8,
   parameter int CLOCKS_PER_PULSE = 4,
   parameter int BITS_PER_WORD    = 8,
   parameter int W_OUT            = R_I*C_I*W_I,
   parameter int NUM_WORDS        = W_OUT/BITS_PER_WORD,
   parameter int TIMEOUT_PULSES   = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             rx,
   uart_frame_rx_if.master  m,
   output logic             frame_err,
   output logic             overrun,
   output logic             timeout
);

   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   localparam int BW = (BITS_PER_WORD > 1) ?
                       $clog2(BITS_PER_WORD) : 1;
   localparam int WW = (NUM_WORDS > 1) ?
                       $clog2(NUM_WORDS) : 1;
   localparam int IW = $clog2(W_OUT);
   localparam int TO_LIM = TIMEOUT_PULSES*CLOCKS_PER_PULSE;
   localparam int TW = $clog2(TO_LIM+1);

   localparam logic [CW-1:0] HALF_END =
      CW'(CLOCKS_PER_PULSE/2-1);
   localparam logic [CW-1:0] FULL_END =
      CW'(CLOCKS_PER_PULSE-1);
   localparam logic [BW-1:0] BIT_END =
      BW'(BITS_PER_WORD-1);
   localparam logic [WW-1:0] WORD_END =
      WW'(NUM_WORDS-1);
   localparam logic [TW-1:0] TO_END =
      TW'(TO_LIM-1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic rx_m;
   logic rx_s;
   logic rx_d;

   logic [CW-1:0] clk_cnt;
   logic [BW-1:0] bit_cnt;
   logic [WW-1:0] word_cnt;
   logic [TW-1:0] to_cnt;

   logic [BITS_PER_WORD-1:0] shreg;
   logic [W_OUT-1:0]         fbuf;
   logic [W_OUT-1:0]         fbuf_nxt;
   logic [IW-1:0]            slot_lo;

   logic             valid_q;
   logic [W_OUT-1:0] data_q;

   logic fall;
   logic cnt_run;
   logic start_smp;
   logic data_smp;
   logic stop_smp;
   logic accept;
   logic ferr;
   logic last;
   logic to_fire;
   logic hs;

   // Two-flop synchroniser plus one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall = rx_d & ~rx_s;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state: hunt edge, confirm start, shift bits, check stop
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (fall) state_nxt = START;
         end
         START: begin
            if (start_smp) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (data_smp && bit_cnt == BIT_END)
               state_nxt = STOP;
         end
         STOP: begin
            if (stop_smp) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: bit-timer enable and per-state sample strobes
   always_comb begin
      cnt_run   = 1'b0;
      start_smp = 1'b0;
      data_smp  = 1'b0;
      stop_smp  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_run = 1'b0;
         end
         START: begin
            cnt_run   = 1'b1;
            start_smp = (clk_cnt == HALF_END);
         end
         DATA: begin
            cnt_run  = 1'b1;
            data_smp = (clk_cnt == FULL_END);
         end
         STOP: begin
            cnt_run  = 1'b1;
            stop_smp = (clk_cnt == FULL_END);
         end
         default: cnt_run = 1'b0;
      endcase
   end

   assign accept  = stop_smp & rx_s;
   assign ferr    = stop_smp & ~rx_s;
   assign last    = accept & (word_cnt == WORD_END);
   assign to_fire = (state == IDLE) &&
                    (word_cnt != '0) &&
                    (to_cnt == TO_END);
   assign hs      = valid_q & m.m_ready;

   // Bit timer restarts at every sample point and idles at zero
   always_ff @(posedge clk) begin
      if (!rstn) begin
         clk_cnt <= '0;
      end else if (!cnt_run || start_smp ||
                   data_smp || stop_smp) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end

   // Data-bit counter and LSB-first shift register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (state == START) begin
         bit_cnt <= '0;
      end else if (data_smp) begin
         shreg   <= {rx_s, shreg[BITS_PER_WORD-1:1]};
         bit_cnt <= (bit_cnt == BIT_END) ?
                    '0 : bit_cnt + 1'b1;
      end
   end

   // Slot counter: advances per good byte, drops partial frames
   always_ff @(posedge clk) begin
      if (!rstn) begin
         word_cnt <= '0;
      end else if (ferr || to_fire) begin
         word_cnt <= '0;
      end else if (accept) begin
         word_cnt <= last ? '0 : word_cnt + 1'b1;
      end
   end

   // Idle timer only runs while a partial frame is pending
   always_ff @(posedge clk) begin
      if (!rstn) begin
         to_cnt <= '0;
      end else if (state != IDLE || word_cnt == '0 ||
                   to_fire) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Frame buffer with the current byte merged into its slot
   always_comb begin
      slot_lo  = IW'(word_cnt) * IW'(BITS_PER_WORD);
      fbuf_nxt = fbuf;
      fbuf_nxt[slot_lo +: BITS_PER_WORD] = shreg;
   end

   // Frame buffer register, decoupled from the output holding reg
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fbuf <= '0;
      end else if (accept) begin
         fbuf <= fbuf_nxt;
      end
   end

   // Output holding register with overrun detection
   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (last) begin
            if (!valid_q || hs) begin
               data_q  <= fbuf_nxt;
               valid_q <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (hs) begin
            valid_q <= 1'b0;
         end
      end
   end

   // Single-cycle error pulses
   always_ff @(posedge clk) begin
      if (!rstn) begin
         frame_err <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         frame_err <= ferr;
         timeout   <= to_fire;
      end
   end

   assign m.m_valid = valid_q;
   assign m.m_data  = data_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: frames, glitches, errors,
// timeout, overrun and mid-byte reset.
module tb_uart_frame_rx;

   localparam int CPP = 4;
   localparam int NW  = 49;
   localparam int W   = NW*8;

   logic clk = 1'b0;
   logic rstn;
   logic rx;
   logic frame_err;
   logic overrun;
   logic timeout;

   uart_frame_rx_if #(.W(W)) bus ();

   uart_frame_rx dut (
      .clk       (clk),
      .rstn      (rstn),
      .rx        (rx),
      .m         (bus),
      .frame_err (frame_err),
      .overrun   (overrun),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_ferr = 0;
   int n_ovr  = 0;
   int n_to   = 0;
   int n_frm  = 0;
   logic [W-1:0] last_frame = '0;

   always @(negedge clk) begin
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (timeout) n_to++;
      if (bus.m_valid && bus.m_ready) begin
         n_frm++;
         last_frame = bus.m_data;
      end
   end

   task automatic chk(input string tag,
                      input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [7:0] base,
                                       input logic [7:0] step);
      logic [W-1:0] f;
      logic [7:0]   v;
      f = '0;
      v = base;
      for (int i = 0; i < NW; i++) begin
         f[i*8 +: 8] = v;
         v = v + step;
      end
      return f;
   endfunction

   task automatic send_byte(input logic [7:0] b,
                            input logic stop);
      rx = 1'b0;
      repeat (CPP) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPP) @(negedge clk);
      end
      rx = stop;
      repeat (CPP) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_bytes(input logic [7:0] base,
                             input logic [7:0] step,
                             input int n);
      logic [7:0] v;
      v = base;
      for (int i = 0; i < n; i++) begin
         send_byte(v, 1'b1);
         v = v + step;
      end
   endtask

   int b_frm;
   int b_ferr;
   int b_ovr;
   int b_to;
   logic [W-1:0] exp_f;

   task automatic snap();
      b_frm  = n_frm;
      b_ferr = n_ferr;
      b_ovr  = n_ovr;
      b_to   = n_to;
   endtask

   initial begin
      rx          = 1'b1;
      rstn        = 1'b0;
      bus.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", W'(bus.m_valid), W'(0));
      chk("rst_data", bus.m_data, '0);
      chk("rst_ferr", W'(frame_err), W'(0));
      chk("rst_ovr", W'(overrun), W'(0));
      chk("rst_to", W'(timeout), W'(0));
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // basic frame 0x01..0x31, latency and byte placement
      bus.m_ready = 1'b1;
      snap();
      exp_f = mk(8'h01, 8'h01);
      send_bytes(8'h01, 8'h01, NW);
      chk("lat_before", W'(bus.m_valid), W'(0));
      @(negedge clk);
      chk("lat_valid", W'(bus.m_valid), W'(1));
      chk("lat_data", bus.m_data, exp_f);
      @(negedge clk);
      chk("lat_drop", W'(bus.m_valid), W'(0));
      repeat (8) @(negedge clk);
      chk("f1_count", W'(n_frm - b_frm), W'(1));
      chk("f1_lo", W'(last_frame[7:0]), W'(8'h01));
      chk("f1_hi", W'(last_frame[391:384]), W'(8'h31));
      chk("f1_ferr", W'(n_ferr - b_ferr), W'(0));
      chk("f1_ovr", W'(n_ovr - b_ovr), W'(0));
      chk("f1_to", W'(n_to - b_to), W'(0));

      // one-clock low glitch must not start a byte
      snap();
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("gl_ferr", W'(n_ferr - b_ferr), W'(0));
      exp_f = mk(8'h40, 8'h01);
      send_bytes(8'h40, 8'h01, NW);
      repeat (8) @(negedge clk);
      chk("gl_count", W'(n_frm - b_frm), W'(1));
      chk("gl_frame", last_frame, exp_f);

      // bad stop bit on the fifth byte drops the partial frame
      snap();
      send_bytes(8'h77, 8'h00, 4);
      send_byte(8'h5A, 1'b0);
      repeat (8) @(negedge clk);
      chk("fe_pulse", W'(n_ferr - b_ferr), W'(1));
      exp_f = mk(8'hA0, 8'h01);
      send_bytes(8'hA0, 8'h01, NW);
      repeat (8) @(negedge clk);
      chk("fe_count", W'(n_frm - b_frm), W'(1));
      chk("fe_lo", W'(last_frame[7:0]), W'(8'hA0));
      chk("fe_frame", last_frame, exp_f);

      // idle timeout discards 20 pending bytes
      snap();
      send_bytes(8'h99, 8'h00, 20);
      repeat (40*CPP) @(negedge clk);
      chk("to_pulse", W'(n_to - b_to), W'(1));
      exp_f = mk(8'h55, 8'h00);
      send_bytes(8'h55, 8'h00, NW);
      repeat (8) @(negedge clk);
      chk("to_count", W'(n_frm - b_frm), W'(1));
      chk("to_frame", last_frame, exp_f);
      chk("to_once", W'(n_to - b_to), W'(1));

      // overrun: downstream stalled across two completions
      bus.m_ready = 1'b0;
      snap();
      exp_f = mk(8'h11, 8'h00);
      send_bytes(8'h11, 8'h00, NW);
      send_bytes(8'h22, 8'h00, NW);
      repeat (8) @(negedge clk);
      chk("ov_valid", W'(bus.m_valid), W'(1));
      chk("ov_data", bus.m_data, exp_f);
      chk("ov_pulse", W'(n_ovr - b_ovr), W'(1));
      @(posedge clk);
      #1 bus.m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ov_hs", W'(n_frm - b_frm), W'(1));
      chk("ov_hsdat", last_frame, exp_f);
      chk("ov_drop", W'(bus.m_valid), W'(0));

      // reset pulse in the middle of byte 30
      snap();
      send_bytes(8'h33, 8'h00, 29);
      rx = 1'b0;
      repeat (CPP) @(negedge clk);
      rx = 1'b1;
      repeat (CPP) @(negedge clk);
      rx = 1'b0;
      repeat (CPP) @(negedge clk);
      rstn = 1'b0;
      rx   = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      chk("mr_valid", W'(bus.m_valid), W'(0));
      chk("mr_data", bus.m_data, '0);
      chk("mr_ferr", W'(frame_err), W'(0));
      repeat (8) @(negedge clk);
      exp_f = mk(8'h60, 8'h01);
      send_bytes(8'h60, 8'h01, NW);
      repeat (8) @(negedge clk);
      chk("mr_count", W'(n_frm - b_frm), W'(1));
      chk("mr_frame", last_frame, exp_f);
      chk("mr_noerr", W'(n_ferr - b_ferr), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d",
               n_chk, n_fail);
      $finish;
   end

endmodule
